// File: rtl/abs_min_max_seq.sv
// Handshaked multi-cycle ABS/MIN/MAX/ABSDIFF unit built around one shared subtractor.
// Results are registered in DONE and held until the consumer accepts them.
module abs_min_max_seq #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    ovf,
  output logic                    busy,
  output logic [7:0]              done_cnt
);

  localparam int M = WIDTH - 1;

  localparam logic [1:0] OP_ABS  = 2'b00;
  localparam logic [1:0] OP_MIN  = 2'b01;
  localparam logic [1:0] OP_MAX  = 2'b10;
  localparam logic [1:0] OP_ADIF = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              op_p0;
  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic signed [WIDTH-1:0] x, y, d;
  logic                    v, lt;
  logic [WIDTH-1:0]        res_nxt;
  logic                    ovf_nxt;

  // |a| with saturation of the most-negative value; returns {ovf, magnitude}.
  // d is 0 - a and v its signed overflow, which is set only for a = -2^(WIDTH-1).
  function automatic logic [WIDTH:0] abs_sat(input logic signed [WIDTH-1:0] av,
                                             input logic signed [WIDTH-1:0] dv,
                                             input logic vv);
    if (!av[M])
      abs_sat = {1'b0, av};
    else if (vv)
      abs_sat = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    else
      abs_sat = {1'b0, dv};
  endfunction

  // Operand capture: data only, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_p0 <= op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  // Single shared subtractor; the operand mux selects the pass.
  always_comb begin
    x = a_p0;
    y = b_p0;
    if (state == EXEC2) begin
      x = b_p0;
      y = a_p0;
    end else if (op_p0 == OP_ABS) begin
      x = '0;
      y = a_p0;
    end
    d  = x - y;
    v  = (x[M] ^ y[M]) & (d[M] ^ x[M]);
    lt = d[M] ^ v;
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = result;
    ovf_nxt   = ovf;
    case (state)
      IDLE: if (in_valid) state_nxt = EXEC1;
      EXEC1: begin
        state_nxt = DONE;
        ovf_nxt   = 1'b0;
        case (op_p0)
          OP_ABS:  {ovf_nxt, res_nxt} = abs_sat(a_p0, d, v);
          OP_MIN:  res_nxt = lt ? a_p0 : b_p0;
          OP_MAX:  res_nxt = lt ? b_p0 : a_p0;
          OP_ADIF: begin
            if (lt) state_nxt = EXEC2;
            else    res_nxt   = d;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        res_nxt   = d;
        ovf_nxt   = 1'b0;
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result   <= '0;
      ovf      <= 1'b0;
      done_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      result <= res_nxt;
      ovf    <= ovf_nxt;
      if (state == DONE && out_ready)
        done_cnt <= done_cnt + 8'd1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_abs_min_max_seq.sv
// Self-checking bench for abs_min_max_seq: directed vector table, reset and
// backpressure sequences, and a random run against an integer reference model.
module tb_abs_min_max_seq;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic signed [7:0] a, b;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        result;
  logic              ovf;
  logic              busy;
  logic [7:0]        done_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_cnt = 8'd0;

  abs_min_max_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic; lat is cycles from acceptance to out_valid.
  task automatic model(input logic [1:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] res, output logic movf, output int lat);
    int sa, sb, r;
    sa = $signed(ma);
    sb = $signed(mb);
    movf = 1'b0;
    lat = 2;
    case (mop)
      2'b00: begin
        if (sa == -128) begin r = 127; movf = 1'b1; end
        else r = (sa < 0) ? -sa : sa;
      end
      2'b01: r = (sa < sb) ? sa : sb;
      2'b10: r = (sa > sb) ? sa : sb;
      default: begin
        r = (sa < sb) ? sb - sa : sa - sb;
        if (sa < sb) lat = 3;
      end
    endcase
    res = r[7:0];
  endtask

  task automatic issue(input logic [1:0] iop, input logic [7:0] ia, input logic [7:0] ib);
    in_valid = 1'b1;
    op = iop;
    a = ia;
    b = ib;
  endtask

  // Called in the cycle the command is presented in IDLE; returns in the first DONE cycle.
  task automatic collect(input logic [7:0] er, input logic eo, input int el, input string nm);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        in_valid = 1'b0;
        op = 2'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end while (!out_valid && k < 10);
    check({nm, " latency"}, out_valid ? k : -1, el);
    check({nm, " result"}, result, er);
    check({nm, " ovf"}, ovf, eo);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    check("take in_ready", in_ready, 1);
    check("take out_valid", out_valid, 0);
    check("take done_cnt", done_cnt, exp_cnt);
  endtask

  initial begin
    logic [7:0] mres;
    logic       movf;
    int         mlat;
    logic       ok;
    logic [7:0] hold_res;
    logic       hold_ovf;

    tbl[0]  = '{2'b01, 8'h7F, 8'h80, 8'h80, 1'b0, 2};
    tbl[1]  = '{2'b10, 8'h7F, 8'h80, 8'h7F, 1'b0, 2};
    tbl[2]  = '{2'b01, 8'h05, 8'h05, 8'h05, 1'b0, 2};
    tbl[3]  = '{2'b10, 8'h05, 8'h05, 8'h05, 1'b0, 2};
    tbl[4]  = '{2'b00, 8'hFB, 8'h33, 8'h05, 1'b0, 2};
    tbl[5]  = '{2'b00, 8'h80, 8'h00, 8'h7F, 1'b1, 2};
    tbl[6]  = '{2'b00, 8'h00, 8'hFF, 8'h00, 1'b0, 2};
    tbl[7]  = '{2'b11, 8'h7F, 8'h80, 8'hFF, 1'b0, 2};
    tbl[8]  = '{2'b11, 8'h80, 8'h7F, 8'hFF, 1'b0, 3};
    tbl[9]  = '{2'b11, 8'h10, 8'h10, 8'h00, 1'b0, 2};
    tbl[10] = '{2'b00, 8'h7F, 8'h00, 8'h7F, 1'b0, 2};
    tbl[11] = '{2'b01, 8'hFD, 8'h02, 8'hFD, 1'b0, 2};
    tbl[12] = '{2'b11, 8'h03, 8'hFB, 8'h08, 1'b0, 2};
    tbl[13] = '{2'b11, 8'hFB, 8'h03, 8'h08, 1'b0, 3};

    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; out_ready = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    check("reset ovf", ovf, 0);
    check("reset done_cnt", done_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      collect(tbl[i].res, tbl[i].ovf, tbl[i].lat, $sformatf("vec%0d", i));
      take();
    end

    // Reset while the command sits in EXEC1.
    issue(2'b01, 8'h05, 8'h03);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    check("midreset in_ready", in_ready, 1);
    check("midreset busy", busy, 0);
    check("midreset result", result, 0);
    check("midreset done_cnt", done_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) ok = 1'b0;
    end
    check("discarded cmd silent", ok, 1);
    issue(2'b10, 8'h85, 8'h03);
    collect(8'h03, 1'b0, 2, "after reset");
    take();

    // Backpressure with a second command waiting on in_valid.
    issue(2'b00, 8'h80, 8'h00);
    collect(8'h7F, 1'b1, 2, "bp first");
    hold_res = result;
    hold_ovf = ovf;
    in_valid = 1'b1; op = 2'b11; a = 8'hF0; b = 8'h10;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== hold_res || ovf !== hold_ovf) ok = 1'b0;
    end
    check("bp held stable", ok, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    check("bp in_ready", in_ready, 1);
    check("bp done_cnt", done_cnt, exp_cnt);
    collect(8'h20, 1'b0, 3, "bp second");
    take();

    // Back-to-back random commands with out_ready tied high.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [1:0] rop;
      logic [7:0] ra, rb;
      rop = 2'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 16 == 0) ra = 8'h80;
      model(rop, ra, rb, mres, movf, mlat);
      issue(rop, ra, rb);
      collect(mres, movf, mlat, $sformatf("rnd%0d op%0d a%0h b%0h", i, rop, ra, rb));
      @(posedge clk); #1;
      exp_cnt++;
    end
    out_ready = 1'b0;
    check("wrap done_cnt", done_cnt, 8'h00);
    check("wrap in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/abs_min_max_seq.md
# abs_min_max_seq

Multi-cycle sequencer that accepts signed-operand commands (ABS, MIN, MAX, ABSDIFF) over a valid/ready handshake and time-shares one subtractor to compute each result. It sits between the LogicCore9 command FSM and the result bus and replaces the free-running single-cycle abs/min/max path with a handshaked, back-pressurable unit. Results are held stable until the consumer takes them.

## Interface
- WIDTH, 8: operand/result width in bits; operands are two's complement.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  command present on op/a/b.
- in_ready  out  1  sequencer can accept a command; high only in IDLE.
- op  in  2  00 ABS(a), 01 MIN(a,b), 10 MAX(a,b), 11 ABSDIFF |a−b|.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B; ignored for ABS.
- out_valid  out  1  result/ovf valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result. Signed for ABS/MIN/MAX; unsigned 0..2^WIDTH−1 for ABSDIFF.
- ovf  out  1  set only for ABS of the most-negative value.
- busy  out  1  high in any state other than IDLE.
- done_cnt  out  8  count of completed handshakes on the output; wraps 255→0.

## Operation
- State machine: IDLE → EXEC1 → (EXEC2) → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, register op, a, b; go to EXEC1. Input is ignored when in_valid=0.
- EXEC1: a single shared subtractor computes d = x − y.
  - ABS: x=0, y=a.
  - Other ops: x=a, y=b.
  - Register d, sign d[MSB], and signed overflow v (operand signs differ and the result sign differs from x).
  - Signed less-than is lt = d[MSB] XOR v.
  - ABS: if a ≥ 0, result=a. If a<0 and a≠−2^(WIDTH−1), result=d. If a=−2^(WIDTH−1), result=2^(WIDTH−1)−1 (saturate) and ovf=1. Go to DONE.
  - MIN: result = lt ? a : b. Go to DONE.
  - MAX: result = lt ? b : a. Go to DONE.
  - ABSDIFF: if lt=0, result = d mod 2^WIDTH and go to DONE. If lt=1, go to EXEC2.
- EXEC2 (ABSDIFF with a<b only): reuse the same subtractor with x=b, y=a. Result = (b−a) mod 2^WIDTH, which is exact as unsigned. Go to DONE.
- ovf=0 for every case other than saturated ABS.
- DONE: out_valid=1; result and ovf stay stable. On out_ready, increment done_cnt and return to IDLE. Otherwise hold indefinitely.
- Equal operands: lt=0. MIN and MAX both return a; ABSDIFF returns 0.
- The subtractor has exactly one instance; both passes go through it.

## Timing
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, ovf=0, done_cnt=0. An in-flight command is discarded and produces no output. Registered outputs stay cleared until the first clock after rst_n rises.
- Cycle n is the cycle where in_valid && in_ready is sampled.
  - ABS, MIN, MAX, and ABSDIFF with a≥b: EXEC1 in n+1; out_valid first high in n+2.
  - ABSDIFF with a<b: EXEC2 in n+2; out_valid first high in n+3.
- DONE with out_ready high in cycle m: IDLE in m+1 (in_ready=1); done_cnt updates at the edge ending m.
- Peak throughput: one command every 3 cycles, or 4 for ABSDIFF with a<b.
- in_ready=0 from n+1 until IDLE is re-entered. Commands presented then are not accepted; the producer must hold them.
- out_ready while out_valid=0 has no effect.
- in_valid/op/a/b changing after acceptance does not affect the in-flight result.

## Test plan
- Reset mid-EXEC1 (op=01, a=5, b=3, rst_n low 1 cycle): out_valid never rises for that command; all outputs read reset values; the next command completes normally.
- MIN/MAX with signed-compare overflow: MIN(a=0x7F, b=0x80) → 0x80 in n+2. MAX of the same operands → 0x7F. MIN(a=0x05, b=0x05) → 0x05.
- ABS: a=0xFB → 0x05, ovf=0. a=0x80 → 0x7F, ovf=1. a=0x00 → 0x00.
- ABSDIFF: a=0x7F, b=0x80 → 0xFF, out_valid in n+2. a=0x80, b=0x7F → 0xFF, out_valid in n+3. a=0x10, b=0x10 → 0x00.
- Backpressure: hold out_ready=0 for 10 cycles. result, ovf and out_valid stay stable; in_ready stays 0; a second command held on in_valid is accepted on the cycle after out_ready=1.
- 256 back-to-back completions with out_ready tied high: done_cnt wraps to 0x00; results match a signed reference model for random op/a/b.
